// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Optional bne support is enabled by defining MIPS_BNE_EN.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } statetype_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

endpackage

// File: rtl/mips_multicycle_controller_aludec.sv
// ALU decoder: maps the FSM's aluop class and the R-type funct field
// onto the 3-bit ALU control code.
module mips_aludec
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // aluop/funct to ALU operation; unknown funct falls back to add
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore FSM sequencing the multicycle MIPS datapath; write enables are
// gated by reset. Define MIPS_BNE_EN to add the bne instruction.
module mips_multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  statetype_t state_r, next_s;
  aluop_t     aluop_s;
  logic       pcwrite_s, branch_s, memwrite_s, irwrite_s, regwrite_s;
`ifdef MIPS_BNE_EN
  logic       branchne_s;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_r <= FETCH;
    else       state_r <= next_s;
  end

  // next-state logic
  always_comb begin
    next_s = FETCH;
    case (state_r)
      FETCH: next_s = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_s = MEMADR;
          OP_RTYPE:     next_s = RTYPEEX;
          OP_BEQ:       next_s = BEQEX;
          OP_ADDI:      next_s = ADDIEX;
          OP_J:         next_s = JEX;
`ifdef MIPS_BNE_EN
          OP_BNE:       next_s = BNEEX;
`endif
          default:      next_s = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_SW) next_s = MEMWR;
        else             next_s = MEMRD;
      end
      MEMRD:   next_s = MEMWB;
      RTYPEEX: next_s = RTYPEWB;
      ADDIEX:  next_s = ADDIWB;
      default: next_s = FETCH;
    endcase
  end

  // Moore output decode of the current state
  always_comb begin
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
`ifdef MIPS_BNE_EN
    branchne_s = 1'b0;
`endif
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop_s    = ALUOP_ADD;
    case (state_r)
      FETCH: begin
        irwrite_s = 1'b1;
        pcwrite_s = 1'b1;
        alusrcb   = 2'b01;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop_s = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      BEQEX: begin
        alusrca  = 1'b1;
        aluop_s  = ALUOP_SUB;
        pcsrc    = 2'b01;
        branch_s = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite_s = 1'b1;
      JEX: begin
        pcsrc     = 2'b10;
        pcwrite_s = 1'b1;
      end
`ifdef MIPS_BNE_EN
      BNEEX: begin
        alusrca    = 1'b1;
        aluop_s    = ALUOP_SUB;
        pcsrc      = 2'b01;
        branchne_s = 1'b1;
      end
`endif
      default: pcwrite_s = 1'b0;
    endcase
  end

  mips_aludec u_aludec (
    .aluop      (aluop_s),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  // reset suppresses every write so an abandoned instruction leaves no trace
  assign memwrite = memwrite_s & ~reset;
  assign irwrite  = irwrite_s  & ~reset;
  assign regwrite = regwrite_s & ~reset;
`ifdef MIPS_BNE_EN
  assign pcen = ~reset & (pcwrite_s | (branch_s & zero) | (branchne_s & ~zero));
`else
  assign pcen = ~reset & (pcwrite_s | (branch_s & zero));
`endif
  assign state = state_r;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Randomized self-checking bench: an instruction-level model gives the
// expected step sequence per opcode and the expected outputs per step.
module tb_mips_multicycle_controller;
  import mips_pkg::*;

  logic       clk, reset, zero;
  logic [5:0] op, funct;
  logic       pcen, memwrite, irwrite, regwrite, iord, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  statetype_t exp_q[$];

  mips_multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (op=%b funct=%b t=%0t)", tag, obs, exp, op, funct, $time);
    end
  endtask

  // expected step sequence of one instruction, from the cycles-per-instruction table
  function automatic void build_seq(input logic [5:0] opc);
    exp_q.delete();
    exp_q.push_back(FETCH);
    exp_q.push_back(DECODE);
    if (opc == 6'b100011) begin
      exp_q.push_back(MEMADR); exp_q.push_back(MEMRD); exp_q.push_back(MEMWB);
    end else if (opc == 6'b101011) begin
      exp_q.push_back(MEMADR); exp_q.push_back(MEMWR);
    end else if (opc == 6'b000000) begin
      exp_q.push_back(RTYPEEX); exp_q.push_back(RTYPEWB);
    end else if (opc == 6'b001000) begin
      exp_q.push_back(ADDIEX); exp_q.push_back(ADDIWB);
    end else if (opc == 6'b000100) begin
      exp_q.push_back(BEQEX);
    end else if (opc == 6'b000010) begin
      exp_q.push_back(JEX);
`ifdef MIPS_BNE_EN
    end else if (opc == 6'b000101) begin
      exp_q.push_back(BNEEX);
`endif
    end
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // compare every output against the per-step table for step s
  task automatic check_step(input statetype_t s);
    logic pw, br, bn, ir, mw, rw, io, rd, mr, sa;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    logic ep;
    {pw, br, bn, ir, mw, rw, io, rd, mr, sa} = 10'b0;
    sb = 2'b00; ps = 2'b00; ac = 3'b010;
    case (s)
      FETCH:   begin ir = 1'b1; pw = 1'b1; sb = 2'b01; end
      DECODE:  sb = 2'b11;
      MEMADR:  begin sa = 1'b1; sb = 2'b10; end
      MEMRD:   io = 1'b1;
      MEMWB:   begin mr = 1'b1; rw = 1'b1; end
      MEMWR:   begin io = 1'b1; mw = 1'b1; end
      RTYPEEX: begin sa = 1'b1; ac = rtype_alu(funct); end
      RTYPEWB: begin rd = 1'b1; rw = 1'b1; end
      BEQEX:   begin sa = 1'b1; ac = 3'b110; ps = 2'b01; br = 1'b1; end
      ADDIEX:  begin sa = 1'b1; sb = 2'b10; end
      ADDIWB:  rw = 1'b1;
      JEX:     begin ps = 2'b10; pw = 1'b1; end
      BNEEX:   begin sa = 1'b1; ac = 3'b110; ps = 2'b01; bn = 1'b1; end
      default: pw = 1'b0;
    endcase
    ep = !reset && (pw || (br && zero) || (bn && !zero));
    check_val("state", 32'(state), 32'(s));
    check_val("pcen", 32'(pcen), 32'(ep));
    check_val("memwrite", 32'(memwrite), 32'(mw && !reset));
    check_val("irwrite", 32'(irwrite), 32'(ir && !reset));
    check_val("regwrite", 32'(regwrite), 32'(rw && !reset));
    check_val("iord", 32'(iord), 32'(io));
    check_val("regdst", 32'(regdst), 32'(rd));
    check_val("memtoreg", 32'(memtoreg), 32'(mr));
    check_val("alusrca", 32'(alusrca), 32'(sa));
    check_val("alusrcb", 32'(alusrcb), 32'(sb));
    check_val("pcsrc", 32'(pcsrc), 32'(ps));
    check_val("alucontrol", 32'(alucontrol), 32'(ac));
  endtask

  // run one instruction from FETCH; zmode 0/1 fixes zero, 2 randomizes it per cycle
  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int zmode);
    op = opc;
    funct = fn;
    build_seq(opc);
    foreach (exp_q[k]) begin
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      #1;
      check_step(exp_q[k]);
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] op_pool[9];
  logic [5:0] fn_pool[6];

  initial begin
    op_pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                6'b000010, 6'b000101, 6'b111111, 6'b000000};
    fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011011};
    reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_step(FETCH);
    reset = 1'b0;
    #1;
    check_step(FETCH);

    // lw from reset, aborted by a 3-cycle reset once it reaches MEMRD
    op = 6'b100011;
    build_seq(op);
    for (int k = 0; k < 3; k++) begin
      zero = 1'($urandom);
      #1; check_step(exp_q[k]);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1; check_step(MEMRD);
    repeat (3) begin
      @(posedge clk); #1;
      zero = 1'($urandom);
      #1; check_step(FETCH);
    end
    reset = 1'b0;
    #1;

    // directed instructions
    run_instr(6'b100011, 6'b000000, 2);
    for (int i = 0; i < 5; i++) run_instr(6'b000000, fn_pool[i], 2);
    run_instr(6'b000100, 6'b000000, 1);
    run_instr(6'b000100, 6'b000000, 0);
    run_instr(6'b000010, 6'b000000, 2);
    run_instr(6'b111111, 6'b000000, 2);
    run_instr(6'b000101, 6'b000000, 0);
    run_instr(6'b000101, 6'b000000, 1);
    run_instr(6'b101011, 6'b000000, 2);
    run_instr(6'b001000, 6'b000000, 2);

    // random instruction stream
    for (int i = 0; i < 300; i++) begin
      logic [5:0] o, f;
      o = ($urandom_range(0, 4) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 8)];
      f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 5)];
      run_instr(o, f, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Control unit for the multicycle MIPS datapath in `mips_computer`. It sequences every instruction through a Moore state machine, one step per `clk` edge, and drives all datapath selects and write enables. It combines a branch condition with the ALU `zero` flag to produce the PC enable. It replaces the single-cycle decoder and shares one ALU and one unified memory port across fetch, address calculation and execute.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `op` in 6: instruction bits [31:26] from the instruction register.
- `funct` in 6: instruction bits [5:0].
- `zero` in 1: ALU result == 0.
- `pcen` out 1: PC register write enable.
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: instruction register load.
- `regwrite` out 1: register file write.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `regdst` out 1: write register select (0 = rt, 1 = rd).
- `memtoreg` out 1: writeback select (0 = ALUOut, 1 = Data).
- `alusrca` out 1: ALU A select (0 = PC, 1 = A).
- `alusrcb` out 2: ALU B select (00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2).
- `pcsrc` out 2: next-PC select (00 = ALUResult, 01 = ALUOut, 10 = jump target).
- `alucontrol` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `state` out 4: current state encoding, for debug and the testbench.

## Operation
- Opcodes:
  - lw 100011
  - sw 101011
  - R-type 000000
  - beq 000100
  - addi 001000
  - j 000010
- State transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR (lw/sw), RTYPEEX, BEQEX, ADDIEX or JEX.
  - Any other opcode in DECODE → FETCH, with no write enables asserted.
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD → MEMWB → FETCH.
  - MEMWR → FETCH.
  - RTYPEEX → RTYPEWB → FETCH.
  - ADDIEX → ADDIWB → FETCH.
  - BEQEX → FETCH.
  - JEX → FETCH.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- `pcen = pcwrite | (branch & zero)`.
- ALU decode:
  - aluop 00 → 010.
  - aluop 01 → 110.
  - aluop 10 → decode funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111. Any other funct → 010.
- Outputs are Moore functions of `state`, except `pcen`, which also depends combinationally on `zero`.

## Timing
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
- Reset:
  - `reset` high at a rising edge → state = FETCH (encoding 0) after that edge.
  - While `reset` is high, `pcen`, `memwrite`, `irwrite` and `regwrite` are forced to 0 regardless of state.
  - All other outputs still follow the current state decode.
  - Reset asserted mid-instruction abandons the instruction; no partial write occurs after the edge at which `reset` is sampled.
- After `reset` falls, the first FETCH outputs are active in the same cycle.
- The first instruction is loaded at the first rising edge with `reset` low.
- `zero` is sampled only in BEQEX (and BNEEX); its value in all other states is ignored.

## Configuration
- `MIPS_BNE_EN` defined:
  - opcode 000101 in DECODE → BNEEX.
  - BNEEX outputs match BEQEX, but assert `branchne` instead of `branch`.
  - `pcen` gains the term `branchne & ~zero`.
  - BNEEX → FETCH; bne takes 3 cycles.
- `MIPS_BNE_EN` undefined: opcode 000101 is unknown and returns to FETCH. There is no `branchne` logic.

## Structure
- Package `mips_pkg` holds:
  - `statetype_t` enum, 4-bit, FETCH=0.
  - `localparam` opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_BNE).
  - Funct constants.
  - `aluop_t`.
- Sub-module `mips_aludec`: combinational mapping from (aluop, funct) to `alucontrol`.
- The top module holds the state register, next-state logic, output decode and `pcen` logic.

## Test plan
- Reset held 3 cycles mid-MEMRD (op=100011) → `state`=0 after the edge; `memwrite`/`regwrite`/`pcen` stay 0 throughout reset.
- lw (op=100011) from reset → states 0,1,2,3,4,0 on successive cycles; `regwrite`=1 and `memtoreg`=1 only in MEMWB; `iord`=1 only in MEMRD.
- R-type `funct` sweep 100000/100010/100100/100101/101010 → `alucontrol` 010/110/000/001/111 in RTYPEEX; `regdst`=1 and `regwrite`=1 in RTYPEWB.
- beq with `zero`=1 → `pcen`=1, `pcsrc`=01 in BEQEX. Same with `zero`=0 → `pcen`=0.
- j (op=000010) → JEX with `pcsrc`=10, `pcen`=1, then FETCH. Opcode 111111 → DECODE → FETCH, with no write enable in DECODE.
- With `MIPS_BNE_EN`: op=000101 and `zero`=0 → `pcen`=1 in BNEEX. Without the macro: same opcode returns to FETCH after DECODE.
